// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath constants: operand width and the one-hot ALU
// operation encoding used by the issue logic, arbiter and ALU.
package riscv;

  localparam int XLEN         = 32;
  localparam int NB_OPERATION = 5;

  // Bit positions inside the one-hot command vector.
  localparam int ADD = 0;
  localparam int SLT = 1;
  localparam int AND = 2;
  localparam int OR  = 3;
  localparam int XOR = 4;

endpackage

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (port 0) and the
// auxiliary address unit (port 1). Each port has a valid/ready request
// channel and a one-deep response buffer. Arbitration is round-robin, or
// fixed priority to port 0 when FIXED_PRIO is set.
module alu_arbiter
  import riscv::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,

  input  logic                    req0_valid_i,
  output logic                    req0_ready_o,
  input  logic [XLEN:0]           req0_rs1_i,
  input  logic [XLEN:0]           req0_rs2_i,
  input  logic [NB_OPERATION-1:0] req0_cmd_i,
  output logic                    rsp0_valid_o,
  input  logic                    rsp0_ready_i,
  output logic [XLEN-1:0]         rsp0_data_o,

  input  logic                    req1_valid_i,
  output logic                    req1_ready_o,
  input  logic [XLEN:0]           req1_rs1_i,
  input  logic [XLEN:0]           req1_rs2_i,
  input  logic [NB_OPERATION-1:0] req1_cmd_i,
  output logic                    rsp1_valid_o,
  input  logic                    rsp1_ready_i,
  output logic [XLEN-1:0]         rsp1_data_o,

  output logic [XLEN:0]           alu_rs1_o,
  output logic [XLEN:0]           alu_rs2_o,
  output logic                    alu_en_o,
  output logic [NB_OPERATION-1:0] alu_cmd_o,
  input  logic [XLEN-1:0]         alu_data_i
);

  // Round-robin pointer: 0 means port 0 wins the next contested cycle.
  logic rr_ptr;

  logic free0, free1;
  logic elig0, elig1;
  logic grant0, grant1;
  logic contested;

  // A slot can take a new result if it is empty or being drained this cycle.
  assign free0     = !rsp0_valid_o | rsp0_ready_i;
  assign free1     = !rsp1_valid_o | rsp1_ready_i;
  assign elig0     = req0_valid_i & free0;
  assign elig1     = req1_valid_i & free1;
  assign contested = elig0 & elig1;

  // Grant selection: a lone eligible port wins; conflicts go to port 0 in
  // fixed-priority mode, otherwise to the port the pointer selects.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (contested) begin
      if (FIXED_PRIO || !rr_ptr) grant0 = 1'b1;
      else                       grant1 = 1'b1;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  // ALU operand mux; operands and command are held at zero when idle so the
  // ALU inputs do not toggle.
  always_comb begin
    alu_en_o  = 1'b0;
    alu_rs1_o = '0;
    alu_rs2_o = '0;
    alu_cmd_o = '0;
    if (grant0) begin
      alu_en_o  = 1'b1;
      alu_rs1_o = req0_rs1_i;
      alu_rs2_o = req0_rs2_i;
      alu_cmd_o = req0_cmd_i;
    end else if (grant1) begin
      alu_en_o  = 1'b1;
      alu_rs1_o = req1_rs1_i;
      alu_rs2_o = req1_rs2_i;
      alu_cmd_o = req1_cmd_i;
    end
  end

  // Pointer moves only on a contested grant, and then points at the loser.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!reset_n)                      rr_ptr <= 1'b0;
    else if (!FIXED_PRIO && contested) rr_ptr <= grant0;
  end

  // Port 0 response buffer: capture on grant, clear when drained without refill.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp0_valid_o <= 1'b0;
      rsp0_data_o  <= '0;
    end else if (grant0) begin
      rsp0_valid_o <= 1'b1;
      rsp0_data_o  <= alu_data_i;
    end else if (rsp0_ready_i) begin
      rsp0_valid_o <= 1'b0;
    end
  end

  // Port 1 response buffer: same behaviour as port 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp1_valid_o <= 1'b0;
      rsp1_data_o  <= '0;
    end else if (grant1) begin
      rsp1_valid_o <= 1'b1;
      rsp1_data_o  <= alu_data_i;
    end else if (rsp1_ready_i) begin
      rsp1_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a round-robin instance driven from a vector
// table plus hand sequences, and a fixed-priority instance driven by hand.
module tb_alu_arbiter;
  import riscv::*;

  localparam logic [NB_OPERATION-1:0] C_ADD = 5'b00001;
  localparam logic [NB_OPERATION-1:0] C_SLT = 5'b00010;
  localparam logic [NB_OPERATION-1:0] C_AND = 5'b00100;
  localparam logic [NB_OPERATION-1:0] C_OR  = 5'b01000;
  localparam logic [NB_OPERATION-1:0] C_XOR = 5'b10000;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference ALU: sum over XLEN+1 bits, SLT returns its top bit.
  function automatic logic [XLEN-1:0] alu_model(input logic [XLEN:0] a, b,
                                                 input logic [NB_OPERATION-1:0] c);
    logic [XLEN:0] sum;
    sum = a + b;
    case (c)
      C_ADD:   return sum[XLEN-1:0];
      C_SLT:   return {{(XLEN-1){1'b0}}, sum[XLEN]};
      C_AND:   return a[XLEN-1:0] & b[XLEN-1:0];
      C_OR:    return a[XLEN-1:0] | b[XLEN-1:0];
      C_XOR:   return a[XLEN-1:0] ^ b[XLEN-1:0];
      default: return '0;
    endcase
  endfunction

  // Round-robin instance signals
  logic v0, v1, r0, r1;
  logic [XLEN:0] a0, b0, a1, b1;
  logic [NB_OPERATION-1:0] c0, c1;
  logic rdy0, rdy1, rv0, rv1, alu_en;
  logic [XLEN-1:0] d0, d1, alu_d;
  logic [XLEN:0] alu_a, alu_b;
  logic [NB_OPERATION-1:0] alu_c;

  assign alu_d = alu_model(alu_a, alu_b, alu_c);

  alu_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (
    .clk(clk), .reset_n(reset_n),
    .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_rs1_i(a0), .req0_rs2_i(b0),
    .req0_cmd_i(c0), .rsp0_valid_o(rv0), .rsp0_ready_i(r0), .rsp0_data_o(d0),
    .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_rs1_i(a1), .req1_rs2_i(b1),
    .req1_cmd_i(c1), .rsp1_valid_o(rv1), .rsp1_ready_i(r1), .rsp1_data_o(d1),
    .alu_rs1_o(alu_a), .alu_rs2_o(alu_b), .alu_en_o(alu_en), .alu_cmd_o(alu_c),
    .alu_data_i(alu_d)
  );

  // Fixed-priority instance signals
  logic fv0, fv1, fr0, fr1;
  logic [XLEN:0] fa0, fb0, fa1, fb1;
  logic [NB_OPERATION-1:0] fc0, fc1;
  logic frdy0, frdy1, frv0, frv1, falu_en;
  logic [XLEN-1:0] fd0, fd1, falu_d;
  logic [XLEN:0] falu_a, falu_b;
  logic [NB_OPERATION-1:0] falu_c;

  assign falu_d = alu_model(falu_a, falu_b, falu_c);

  alu_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .req0_valid_i(fv0), .req0_ready_o(frdy0), .req0_rs1_i(fa0), .req0_rs2_i(fb0),
    .req0_cmd_i(fc0), .rsp0_valid_o(frv0), .rsp0_ready_i(fr0), .rsp0_data_o(fd0),
    .req1_valid_i(fv1), .req1_ready_o(frdy1), .req1_rs1_i(fa1), .req1_rs2_i(fb1),
    .req1_cmd_i(fc1), .rsp1_valid_o(frv1), .rsp1_ready_i(fr1), .rsp1_data_o(fd1),
    .alu_rs1_o(falu_a), .alu_rs2_o(falu_b), .alu_en_o(falu_en), .alu_cmd_o(falu_c),
    .alu_data_i(falu_d)
  );

  typedef struct {
    logic v0; logic [XLEN:0] a0, b0; logic [NB_OPERATION-1:0] c0;
    logic v1; logic [XLEN:0] a1, b1; logic [NB_OPERATION-1:0] c1;
    logic r0, r1;
    logic g0, g1;
    logic rv0; logic [XLEN-1:0] d0;
    logic rv1; logic [XLEN-1:0] d1;
  } vec_t;

  function automatic vec_t mk(input logic v0_, input logic [XLEN:0] a0_, b0_,
                              input logic [NB_OPERATION-1:0] c0_,
                              input logic v1_, input logic [XLEN:0] a1_, b1_,
                              input logic [NB_OPERATION-1:0] c1_,
                              input logic r0_, r1_, g0_, g1_,
                              input logic rv0_, input logic [XLEN-1:0] d0_,
                              input logic rv1_, input logic [XLEN-1:0] d1_);
    vec_t t;
    t.v0 = v0_; t.a0 = a0_; t.b0 = b0_; t.c0 = c0_;
    t.v1 = v1_; t.a1 = a1_; t.b1 = b1_; t.c1 = c1_;
    t.r0 = r0_; t.r1 = r1_; t.g0 = g0_; t.g1 = g1_;
    t.rv0 = rv0_; t.d0 = d0_; t.rv1 = rv1_; t.d1 = d1_;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_rr(input logic v0_, input logic [XLEN:0] a0_, b0_,
                          input logic [NB_OPERATION-1:0] c0_,
                          input logic v1_, input logic [XLEN:0] a1_, b1_,
                          input logic [NB_OPERATION-1:0] c1_,
                          input logic r0_, r1_);
    v0 = v0_; a0 = a0_; b0 = b0_; c0 = c0_;
    v1 = v1_; a1 = a1_; b1 = b1_; c1 = c1_;
    r0 = r0_; r1 = r1_;
  endtask

  vec_t vecs[$];

  initial begin
    reset_n = 1'b0;
    drive_rr(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    fv0 = 0; fa0 = 0; fb0 = 0; fc0 = 0; fv1 = 0; fa1 = 0; fb1 = 0; fc1 = 0;
    fr0 = 1; fr1 = 1;

    // v0  a0            b0            c0     v1  a1           b1           c1     r0 r1 g0 g1 rv0 d0        rv1 d1
    vecs.push_back(mk(0, 0,            0,            0,     0, 0,           0,           0,     1, 1, 0, 0, 0, 32'h0,    0, 32'h0));
    vecs.push_back(mk(1, 5,            7,            C_ADD, 0, 0,           0,           0,     1, 1, 1, 0, 1, 32'd12,   0, 32'h0));
    vecs.push_back(mk(0, 0,            0,            0,     0, 0,           0,           0,     1, 1, 0, 0, 0, 32'd12,   0, 32'h0));
    vecs.push_back(mk(1, 33'hF0F0,     33'h0FF0,     C_AND, 1, 33'h1,       33'h2,       C_OR,  1, 1, 1, 0, 1, 32'hF0,   0, 32'h0));
    vecs.push_back(mk(1, 33'hF0F0,     33'h0FF0,     C_AND, 1, 33'h1,       33'h2,       C_OR,  1, 1, 0, 1, 0, 32'hF0,   1, 32'h3));
    vecs.push_back(mk(1, 33'hF0F0,     33'h0FF0,     C_AND, 1, 33'h1,       33'h2,       C_OR,  1, 1, 1, 0, 1, 32'hF0,   0, 32'h3));
    vecs.push_back(mk(1, 33'hF0F0,     33'h0FF0,     C_AND, 1, 33'h1,       33'h2,       C_OR,  1, 1, 0, 1, 0, 32'hF0,   1, 32'h3));
    vecs.push_back(mk(1, 1,            1,            C_ADD, 0, 0,           0,           0,     0, 1, 1, 0, 1, 32'h2,    0, 32'h3));
    vecs.push_back(mk(1, 2,            2,            C_ADD, 1, 33'hFF,      33'h0F,      C_XOR, 0, 1, 0, 1, 1, 32'h2,    1, 32'hF0));
    vecs.push_back(mk(1, 2,            2,            C_ADD, 0, 0,           0,           0,     1, 1, 1, 0, 1, 32'h4,    0, 32'hF0));
    vecs.push_back(mk(0, 0,            0,            0,     1, 33'h3,       33'h1FFFFFFFB, C_SLT, 1, 1, 0, 1, 0, 32'h4,  1, 32'h1));
    vecs.push_back(mk(1, 5,            5,            0,     0, 0,           0,           0,     1, 1, 1, 0, 1, 32'h0,    0, 32'h1));

    repeat (2) @(posedge clk);
    #1;
    check("reset rsp0_valid", rv0, 0);
    check("reset rsp1_valid", rv1, 0);
    check("reset rsp0_data", d0, 0);
    check("reset rsp1_data", d1, 0);
    check("reset alu_en", alu_en, 0);
    check("fp reset rsp0_valid", frv0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      logic [XLEN:0] ea, eb;
      logic [NB_OPERATION-1:0] ec;
      @(negedge clk);
      drive_rr(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].c0,
               vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].c1, vecs[i].r0, vecs[i].r1);
      ea = vecs[i].g0 ? vecs[i].a0 : (vecs[i].g1 ? vecs[i].a1 : '0);
      eb = vecs[i].g0 ? vecs[i].b0 : (vecs[i].g1 ? vecs[i].b1 : '0);
      ec = vecs[i].g0 ? vecs[i].c0 : (vecs[i].g1 ? vecs[i].c1 : '0);
      #1;
      check($sformatf("vec%0d req0_ready", i), rdy0, vecs[i].g0);
      check($sformatf("vec%0d req1_ready", i), rdy1, vecs[i].g1);
      check($sformatf("vec%0d alu_en", i), alu_en, vecs[i].g0 | vecs[i].g1);
      check($sformatf("vec%0d alu_rs1", i), alu_a, ea);
      check($sformatf("vec%0d alu_rs2", i), alu_b, eb);
      check($sformatf("vec%0d alu_cmd", i), alu_c, ec);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d rsp0_valid", i), rv0, vecs[i].rv0);
      check($sformatf("vec%0d rsp0_data", i), d0, vecs[i].d0);
      check($sformatf("vec%0d rsp1_valid", i), rv1, vecs[i].rv1);
      check($sformatf("vec%0d rsp1_data", i), d1, vecs[i].d1);
    end

    // Fill both slots, then reset asynchronously mid-cycle.
    @(negedge clk);
    drive_rr(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    drive_rr(1, 1, 2, C_ADD, 1, 3, 4, C_ADD, 0, 0);
    #1;
    check("fill contested req0_ready", rdy0, 1);
    check("fill contested req1_ready", rdy1, 0);
    @(negedge clk);
    #1;
    check("fill stalled req0_ready", rdy0, 0);
    check("fill req1_ready", rdy1, 1);
    @(posedge clk);
    #1;
    check("fill rsp0_valid", rv0, 1);
    check("fill rsp0_data", d0, 3);
    check("fill rsp1_valid", rv1, 1);
    check("fill rsp1_data", d1, 7);
    @(negedge clk);
    drive_rr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset rsp0_valid", rv0, 0);
    check("async reset rsp1_valid", rv1, 0);
    check("async reset rsp0_data", d0, 0);
    check("async reset rsp1_data", d1, 0);
    @(negedge clk);
    reset_n = 1'b1;
    drive_rr(1, 1, 2, C_ADD, 1, 3, 4, C_ADD, 1, 1);
    #1;
    check("post reset req0_ready", rdy0, 1);
    check("post reset req1_ready", rdy1, 0);
    @(posedge clk);
    #1;
    check("post reset rsp0_data", d0, 3);
    check("post reset rsp1_valid", rv1, 0);
    @(negedge clk);
    drive_rr(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

    // Fixed priority: port 0 wins every conflict.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      fv0 = 1; fa0 = 33'hF0F0; fb0 = 33'h0FF0; fc0 = C_AND;
      fv1 = 1; fa1 = 33'h1;    fb1 = 33'h2;    fc1 = C_OR;
      #1;
      check($sformatf("fp cyc%0d req0_ready", k), frdy0, 1);
      check($sformatf("fp cyc%0d req1_ready", k), frdy1, 0);
      @(posedge clk);
      #1;
      check($sformatf("fp cyc%0d rsp0_data", k), fd0, 32'hF0);
      check($sformatf("fp cyc%0d rsp1_valid", k), frv1, 0);
    end
    @(negedge clk);
    fv0 = 0; fa0 = 0; fb0 = 0; fc0 = 0;
    #1;
    check("fp port1 req1_ready", frdy1, 1);
    check("fp port1 req0_ready", frdy0, 0);
    @(posedge clk);
    #1;
    check("fp port1 rsp1_valid", frv1, 1);
    check("fp port1 rsp1_data", fd1, 32'h3);
    @(negedge clk);
    fv1 = 0; fa1 = 0; fb1 = 0; fc1 = 0;
    #1;
    check("fp idle alu_en", falu_en, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: port 0 is the execute stage, port 1 is the auxiliary unit (branch/CSR address calculation).
- Each port has a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin, or fixed priority when configured.
- Each port owns a one-deep response buffer, so the block sits between the issue logic and the ALU instance.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between ports; 1 = port 0 always wins a conflict.
- XLEN, NB_OPERATION and the op indices ADD/SLT/AND/OR/XOR come from the riscv package. They are not redeclared here.

Ports:
- clk  in  1  core clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req0_valid_i  in  1  port 0 request valid
- req0_ready_o  out  1  port 0 request accepted this cycle
- req0_rs1_i  in  XLEN+1  port 0 operand 1 (bit XLEN = sign extension)
- req0_rs2_i  in  XLEN+1  port 0 operand 2
- req0_cmd_i  in  NB_OPERATION  port 0 one-hot operation
- rsp0_valid_o  out  1  port 0 result valid
- rsp0_ready_i  in  1  port 0 result consumed
- rsp0_data_o  out  XLEN  port 0 result
- req1_valid_i, req1_ready_o, req1_rs1_i, req1_rs2_i, req1_cmd_i, rsp1_valid_o, rsp1_ready_i, rsp1_data_o: same as port 0, for port 1
- alu_rs1_o  out  XLEN+1  operand 1 to ALU
- alu_rs2_o  out  XLEN+1  operand 2 to ALU
- alu_en_o  out  1  ALU enable
- alu_cmd_o  out  NB_OPERATION  operation to ALU
- alu_data_i  in  XLEN  ALU result (combinational)

Behaviour:
- Reset: rsp0/1_valid_o=0, rsp0/1_data_o=0, round-robin pointer=0 (port 0 preferred next). Reset is asynchronous and applies mid-operation: buffered results are discarded and no response is emitted for them.
- Slot free for port k: `free_k = !rspk_valid_o | rspk_ready_i`. Draining and refilling the same slot in one cycle is allowed.
- Eligibility: port k is eligible when `reqk_valid_i & free_k`.
- Grant is combinational, at most one port per cycle:
  - only one port eligible → it wins;
  - both eligible, FIXED_PRIO=1 → port 0 wins;
  - both eligible, FIXED_PRIO=0 → the port selected by the pointer wins.
- Handshake: `reqk_ready_o = grant_k`. A request is consumed on a clock edge where valid & ready are both 1.
- A port whose response slot is full and not draining gets ready=0, while the other port can still be granted in that cycle.
- ALU drive:
  - on grant: alu_en_o=1, and alu_rs1_o/alu_rs2_o/alu_cmd_o come from the winning port;
  - with no grant: alu_en_o=0, and operands/cmd are driven to all-zero (no toggling).
- Result capture: on a grant edge, `rspk_data_o <= alu_data_i` and `rspk_valid_o <= 1`.
- Latency is exactly 1 cycle: a request accepted at edge N has its result valid from edge N.
- Response hold: rspk_valid_o stays high and rspk_data_o stays stable until rspk_ready_i=1. If no new grant to that port occurs at the drain edge, valid clears.
- Pointer update, round-robin mode:
  - updated only on a contested grant;
  - it then points to the loser, so a continuously requesting port waits at most 1 cycle;
  - uncontested grants leave the pointer unchanged.
- Requester rules (bench assertions): valid must not drop and payload must not change while valid=1 & ready=0. cmd must be one-hot or zero; zero cmd yields result 0.
- Widths: operands pass through unmodified at XLEN+1. Results are XLEN and follow the ALU semantics (SLT result is bit XLEN of the sum, zero-extended).
- Throughput: one result per port per cycle when rsp_ready_i is held high. Combined throughput is one op per cycle.

Test Plan:
- Single port 0: cmd=ADD, rs1=5, rs2=7, rsp0_ready_i=1 → req0_ready_o=1 same cycle; next cycle rsp0_valid_o=1, rsp0_data_o=12; alu_en_o=0 when idle.
- Contention, FIXED_PRIO=0: both valid every cycle (port 0 AND 0xF0F0,0x0FF0; port 1 OR 0x1,0x2) → grants alternate 0,1,0,1 starting with port 0; results 0x00F0 and 0x3 on respective ports.
- Contention, FIXED_PRIO=1: both valid for 4 cycles → port 0 granted 4 times, port 1 only when req0_valid_i drops.
- Backpressure: port 0 result buffered, rsp0_ready_i=0, new req0 pending, req1 XOR 0xFF,0x0F valid → req0_ready_o=0, port 1 granted, rsp1_data_o=0xF0; rsp0_data_o held stable. When rsp0_ready_i=1, port 0 is granted the same cycle and its new result appears at the next cycle.
- Reset mid-operation: assert reset_n=0 with both response slots valid → rsp valids and data go to 0 immediately (asynchronous). After release, the first contested grant goes to port 0.
- SLT path: cmd=SLT, rs1=3, rs2=-5 (two's complement, XLEN+1 bits, as supplied by the issue stage) → rsp data = bit XLEN of the sum, zero-extended, matching a direct ALU model.
